mac4x4_feeder: RTL and testbench

//  Upstream driver and result collector for the 4x4 MAC array.

---
 rtl/mac4x4_feeder_if.sv | 48 ++++
 rtl/mac4x4_feeder.sv | 141 ++++++++++++++
 tb/tb_mac4x4_feeder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac4x4_feeder_if.sv
// Bundles the command, A-row, MAC and output-row signals of the 4x4 MAC feeder.
// Latency: none, wiring only.
// Backpressure: carries cmd_rdy, a_rdy and o_rdy alongside their valids.
interface mac4x4_feeder_if #(
  parameter int ROWS = 16,
  parameter int DW   = 16,
  parameter int BW   = 5
);
  localparam int RW = $clog2(ROWS);

  // command channel
  logic              cmd_v;
  logic              cmd_rdy;
  logic [RW-1:0]     cmd_rows;
  logic [BW-1:0]     cmd_bidx;
  logic              cmd_first;
  logic              cmd_last;
  // A row channel
  logic              a_v;
  logic              a_rdy;
  logic [4*DW-1:0]   a_data;
  // MAC array side
  logic              mac_en;
  logic [4*DW-1:0]   mac_a;
  logic [BW-1:0]     mac_bidx;
  logic [4*DW-1:0]   mac_c;
  logic              mac_r_v;
  logic [4*DW-1:0]   mac_r;
  // result row channel
  logic              o_v;
  logic              o_rdy;
  logic [4*DW-1:0]   o_data;
  logic              o_last;

  // environment side: issues commands and rows, models the MAC, sinks results
  modport master (
    output cmd_v, cmd_rows, cmd_bidx, cmd_first, cmd_last,
    output a_v, a_data, mac_r_v, mac_r, o_rdy,
    input  cmd_rdy, a_rdy, mac_en, mac_a, mac_bidx, mac_c, o_v, o_data, o_last
  );

  // feeder side
  modport slave (
    input  cmd_v, cmd_rows, cmd_bidx, cmd_first, cmd_last,
    input  a_v, a_data, mac_r_v, mac_r, o_rdy,
    output cmd_rdy, a_rdy, mac_en, mac_a, mac_bidx, mac_c, o_v, o_data, o_last
  );
endinterface

// File: rtl/mac4x4_feeder.sv
// Feeds A rows plus accumulator rows into the 4x4 MAC and collects results into a local buffer.
// Latency: command to first mac_en 2 cycles; mac_en 1 cycle after each A handshake; 1 row/cycle.
// Backpressure: cmd_rdy only in IDLE, a_rdy only in FEED; o_rdy low holds o_data/o_last stable.
module mac4x4_feeder #(
  parameter int ROWS = 16,
  parameter int DW   = 16,
  parameter int BW   = 5
) (
  input  logic           clock,
  input  logic           reset,
  mac4x4_feeder_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = RW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]      state;
  logic [RW-1:0]   rows_q;
  logic [BW-1:0]   bidx_q;
  logic            first_q;
  logic            last_q;
  logic [CW-1:0]   issue_cnt;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   rows_ext;
  logic [CW-1:0]   row_end;

  logic            mac_en_q;
  logic [4*DW-1:0] mac_a_q;
  logic [BW-1:0]   mac_bidx_q;
  logic [4*DW-1:0] mac_c_q;

  // accumulator buffer; contents survive reset and are only trusted after a first pass
  logic [4*DW-1:0] acc [ROWS];

  logic cmd_hs;
  logic a_hs;
  logic o_hs;
  logic r_take;

  // rows_q is "rows minus one", so row_end is the row count of the pass
  assign rows_ext = {1'b0, rows_q};
  assign row_end  = rows_ext + CW'(1);

  // cmd_rdy is forced low during reset so every output reads 0 while reset is held
  assign bus.cmd_rdy  = (state == S_IDLE) && !reset;
  assign bus.a_rdy    = (state == S_FEED) && (issue_cnt < row_end);
  assign bus.o_v      = (state == S_OUT);
  assign bus.o_data   = (state == S_OUT) ? acc[out_cnt[RW-1:0]] : '0;
  assign bus.o_last   = (state == S_OUT) && (out_cnt == rows_ext);

  assign bus.mac_en   = mac_en_q;
  assign bus.mac_a    = mac_a_q;
  assign bus.mac_bidx = mac_bidx_q;
  assign bus.mac_c    = mac_c_q;

  assign cmd_hs = bus.cmd_v && bus.cmd_rdy;
  assign a_hs   = bus.a_v && bus.a_rdy;
  assign o_hs   = bus.o_v && bus.o_rdy;
  assign r_take = bus.mac_r_v && (state != S_IDLE);

  // pass sequencing: latch command, count issued rows, wait for results, stream out
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rows_q    <= '0;
      bidx_q    <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      issue_cnt <= '0;
      out_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_hs) begin
            rows_q    <= bus.cmd_rows;
            bidx_q    <= bus.cmd_bidx;
            first_q   <= bus.cmd_first;
            last_q    <= bus.cmd_last;
            issue_cnt <= '0;
            out_cnt   <= '0;
            state     <= S_FEED;
          end
        end
        S_FEED: begin
          if (a_hs) begin
            issue_cnt <= issue_cnt + CW'(1);
            if (issue_cnt == rows_ext) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wr_cnt == row_end) state <= last_q ? S_OUT : S_IDLE;
        end
        S_OUT: begin
          if (o_hs) begin
            out_cnt <= out_cnt + CW'(1);
            if (bus.o_last) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // result write pointer: restarts with each command, steps on every accepted MAC result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
    end else if (cmd_hs) begin
      wr_cnt <= '0;
    end else if (r_take) begin
      wr_cnt <= wr_cnt + CW'(1);
    end
  end

  // MAC drive: one registered beat per accepted A row; c is read before that row's result lands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mac_en_q   <= 1'b0;
      mac_a_q    <= '0;
      mac_bidx_q <= '0;
      mac_c_q    <= '0;
    end else begin
      mac_en_q <= a_hs;
      if (a_hs) begin
        mac_a_q    <= bus.a_data;
        mac_bidx_q <= bidx_q;
        mac_c_q    <= first_q ? '0 : acc[issue_cnt[RW-1:0]];
      end
    end
  end

  // result capture into the accumulator buffer, stored verbatim
  always_ff @(posedge clock) begin
    if (r_take) acc[wr_cnt[RW-1:0]] <= bus.mac_r;
  end
endmodule

// File: tb/tb_mac4x4_feeder.sv
`timescale 1ns/1ps
module tb_mac4x4_feeder;
  localparam int ROWS = 16;
  localparam int DW   = 16;
  localparam int BW   = 5;
  localparam int RW   = $clog2(ROWS);
  typedef logic [4*DW-1:0] row_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mac4x4_feeder_if #(.ROWS(ROWS), .DW(DW), .BW(BW)) bus ();
  mac4x4_feeder #(.ROWS(ROWS), .DW(DW), .BW(BW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // reference accumulator contents, updated pass by pass from the arithmetic rules
  row_t model_acc [ROWS];

  // observations of one pass
  row_t            obs_a[$];
  row_t            obs_c[$];
  logic [BW-1:0]   obs_b[$];
  row_t            obs_o[$];
  bit              obs_last[$];
  int              en_cyc[$];
  int              hs_cyc[$];
  int              acc_cyc;
  int              hold_err;
  bit              timed_out;

  function automatic row_t lane_add(row_t x, row_t y);
    row_t s;
    for (int l = 0; l < 4; l++) s[l*DW +: DW] = x[l*DW +: DW] + y[l*DW +: DW];
    return s;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  // MAC array stand-in with B = identity: r = a + c per lane, one cycle after mac_en
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.mac_r_v <= 1'b0;
      bus.mac_r   <= '0;
    end else begin
      bus.mac_r_v <= bus.mac_en;
      bus.mac_r   <= lane_add(bus.mac_a, bus.mac_c);
    end
  end

  // expected c per row and new accumulator contents for one pass
  task automatic ref_pass(input int rows, input bit first, input row_t a[ROWS], output row_t ec[ROWS]);
    for (int i = 0; i < ROWS; i++) ec[i] = '0;
    for (int i = 0; i <= rows; i++) begin
      ec[i] = first ? '0 : model_acc[i];
      model_acc[i] = lane_add(a[i], ec[i]);
    end
  endtask

  // drives one command plus its rows, sinks outputs, records what the DUT did
  task automatic run_pass(input int rows, input logic [BW-1:0] bidx, input bit first, input bit last,
                          input row_t arows[ROWS], input bit bubble, input int bp_at, input int bp_len);
    int cyc = 0, ai = 0, outs = 0, bp_left = 0;
    bit accepted = 0, done = 0, bp_used = 0, prev_hs = 0, prev_stall = 0, prev_last = 0;
    row_t prev_o = '0;
    obs_a.delete(); obs_c.delete(); obs_b.delete(); obs_o.delete(); obs_last.delete();
    en_cyc.delete(); hs_cyc.delete();
    acc_cyc = -1; hold_err = 0; timed_out = 0;
    while (!done) begin
      @(negedge clock);
      if (bus.mac_en) begin
        obs_a.push_back(bus.mac_a); obs_c.push_back(bus.mac_c); obs_b.push_back(bus.mac_bidx);
        en_cyc.push_back(cyc);
      end
      if (prev_stall && (!bus.o_v || bus.o_data !== prev_o || bus.o_last !== prev_last)) hold_err++;
      if (accepted && ai > rows && bus.cmd_rdy && (!last || outs == rows + 1)) done = 1;
      else if (cyc > 4000) begin done = 1; timed_out = 1; end
      if (!done) begin
        if (!accepted) begin
          bus.cmd_v = 1'b1; bus.cmd_rows = rows[RW-1:0]; bus.cmd_bidx = bidx;
          bus.cmd_first = first; bus.cmd_last = last;
          if (bus.cmd_rdy) begin accepted = 1; acc_cyc = cyc; end
        end else begin
          bus.cmd_v = 1'b0;
        end
        if (ai <= rows) begin
          bus.a_v = !(bubble && prev_hs);
          bus.a_data = arows[ai];
        end else begin
          bus.a_v = 1'b0;
        end
        prev_hs = bus.a_v && bus.a_rdy;
        if (prev_hs) begin hs_cyc.push_back(cyc); ai++; end
        if (bp_left > 0) begin
          bus.o_rdy = 1'b0; bp_left--;
        end else if (!bp_used && bp_len > 0 && outs == bp_at && bus.o_v) begin
          bus.o_rdy = 1'b0; bp_used = 1; bp_left = bp_len - 1;
        end else begin
          bus.o_rdy = 1'b1;
        end
        prev_stall = bus.o_v && !bus.o_rdy;
        prev_o = bus.o_data; prev_last = bus.o_last;
        if (bus.o_v && bus.o_rdy) begin
          obs_o.push_back(bus.o_data); obs_last.push_back(bus.o_last); outs++;
        end
        cyc++;
      end
    end
    bus.cmd_v = 1'b0; bus.a_v = 1'b0; bus.o_rdy = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clock);
    n_chk++;
    if ({bus.cmd_rdy, bus.a_rdy, bus.mac_en, bus.o_v, bus.o_last} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got=%b want=00000", {bus.cmd_rdy, bus.a_rdy, bus.mac_en, bus.o_v, bus.o_last});
    end
    n_chk++;
    if ({bus.mac_a, bus.mac_c, bus.mac_bidx, bus.o_data} !== '0) begin
      n_err++; $display("FAIL reset_data mac_a=%h mac_c=%h bidx=%h o_data=%h want all 0", bus.mac_a, bus.mac_c, bus.mac_bidx, bus.o_data);
    end
    reset = 1'b0;
    @(negedge clock);
    n_chk++;
    if (bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL reset_release_cmd_rdy got=%b want=1", bus.cmd_rdy); end
  endtask

  task automatic test_single_pass;
    row_t a[ROWS]; row_t ec[ROWS]; logic [BW-1:0] b;
    for (int i = 0; i < ROWS; i++) a[i] = rand_row();
    b = BW'($urandom_range(0, 31));
    ref_pass(3, 1'b1, a, ec);
    run_pass(3, b, 1'b1, 1'b1, a, 1'b0, 0, 0);
    n_chk++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL single_timeout got=1 want=0"); end
    n_chk++; if (obs_a.size() !== 4) begin n_err++; $display("FAIL single_mac_count got=%0d want=4", obs_a.size()); end
    n_chk++; if (en_cyc.size() > 0 && en_cyc[0] - acc_cyc !== 2) begin n_err++; $display("FAIL single_latency got=%0d want=2", en_cyc[0] - acc_cyc); end
    for (int i = 0; i < obs_a.size() && i < 4; i++) begin
      n_chk++;
      if (obs_a[i] !== a[i] || obs_c[i] !== ec[i] || obs_b[i] !== b || en_cyc[i] !== en_cyc[0] + i) begin
        n_err++; $display("FAIL single_mac_row%0d a=%h c=%h bidx=%0d cyc=%0d want a=%h c=%h bidx=%0d cyc=%0d", i, obs_a[i], obs_c[i], obs_b[i], en_cyc[i], a[i], ec[i], b, en_cyc[0] + i);
      end
    end
    n_chk++; if (obs_o.size() !== 4) begin n_err++; $display("FAIL single_out_count got=%0d want=4", obs_o.size()); end
    for (int i = 0; i < obs_o.size() && i < 4; i++) begin
      n_chk++;
      if (obs_o[i] !== model_acc[i] || obs_last[i] !== (i == 3)) begin
        n_err++; $display("FAIL single_out_row%0d data=%h last=%b want data=%h last=%b", i, obs_o[i], obs_last[i], model_acc[i], i == 3);
      end
    end
  endtask

  task automatic test_two_pass;
    row_t a1[ROWS]; row_t a2[ROWS]; row_t ec[ROWS];
    for (int i = 0; i < ROWS; i++) begin a1[i] = {4{16'h0001}}; a2[i] = {4{16'h0002}}; end
    ref_pass(3, 1'b1, a1, ec);
    run_pass(3, 5'd7, 1'b1, 1'b0, a1, 1'b0, 0, 0);
    n_chk++; if (timed_out !== 1'b0 || obs_o.size() !== 0) begin n_err++; $display("FAIL two_pass1 timeout=%b outs=%0d want 0/0", timed_out, obs_o.size()); end
    ref_pass(3, 1'b0, a2, ec);
    run_pass(3, 5'd9, 1'b0, 1'b1, a2, 1'b0, 0, 0);
    n_chk++; if (timed_out !== 1'b0 || obs_c.size() !== 4 || obs_o.size() !== 4) begin
      n_err++; $display("FAIL two_pass2_counts timeout=%b macs=%0d outs=%0d want 0/4/4", timed_out, obs_c.size(), obs_o.size());
    end
    for (int i = 0; i < obs_c.size() && i < 4; i++) begin
      n_chk++; if (obs_c[i] !== ec[i]) begin n_err++; $display("FAIL two_pass_c_row%0d got=%h want=%h", i, obs_c[i], ec[i]); end
    end
    for (int i = 0; i < obs_o.size() && i < 4; i++) begin
      n_chk++; if (obs_o[i] !== model_acc[i] || obs_last[i] !== (i == 3)) begin
        n_err++; $display("FAIL two_pass_out_row%0d data=%h last=%b want data=%h last=%b", i, obs_o[i], obs_last[i], model_acc[i], i == 3);
      end
    end
    n_chk++; if (obs_o.size() > 0 && obs_o[0] !== {4{16'h0003}}) begin n_err++; $display("FAIL two_pass_sum got=%h want=%h", obs_o[0], {4{16'h0003}}); end
  endtask

  task automatic test_bubbles;
    row_t a[ROWS]; row_t ec[ROWS];
    for (int i = 0; i < ROWS; i++) a[i] = rand_row();
    ref_pass(5, 1'b1, a, ec);
    run_pass(5, 5'd3, 1'b1, 1'b1, a, 1'b1, 0, 0);
    n_chk++; if (timed_out !== 1'b0 || obs_a.size() !== 6 || hs_cyc.size() !== 6) begin
      n_err++; $display("FAIL bubble_counts timeout=%b macs=%0d hs=%0d want 0/6/6", timed_out, obs_a.size(), hs_cyc.size());
    end
    for (int i = 0; i < obs_a.size() && i < hs_cyc.size() && i < 6; i++) begin
      n_chk++;
      if (en_cyc[i] !== hs_cyc[i] + 1 || obs_a[i] !== a[i] || (i > 0 && hs_cyc[i] - hs_cyc[i-1] !== 2)) begin
        n_err++; $display("FAIL bubble_row%0d en_cyc=%0d hs_cyc=%0d a=%h want en_cyc=%0d a=%h", i, en_cyc[i], hs_cyc[i], obs_a[i], hs_cyc[i] + 1, a[i]);
      end
    end
    for (int i = 0; i < obs_o.size() && i < 6; i++) begin
      n_chk++; if (obs_o[i] !== model_acc[i]) begin n_err++; $display("FAIL bubble_out_row%0d got=%h want=%h", i, obs_o[i], model_acc[i]); end
    end
  endtask

  task automatic test_backpressure;
    row_t a[ROWS]; row_t ec[ROWS];
    for (int i = 0; i < ROWS; i++) a[i] = rand_row();
    ref_pass(7, 1'b1, a, ec);
    run_pass(7, 5'd21, 1'b1, 1'b1, a, 1'b0, 3, 5);
    n_chk++; if (timed_out !== 1'b0 || obs_o.size() !== 8) begin n_err++; $display("FAIL bp_counts timeout=%b outs=%0d want 0/8", timed_out, obs_o.size()); end
    n_chk++; if (hold_err !== 0) begin n_err++; $display("FAIL bp_hold unstable_cycles=%0d want=0", hold_err); end
    for (int i = 0; i < obs_o.size() && i < 8; i++) begin
      n_chk++; if (obs_o[i] !== model_acc[i] || obs_last[i] !== (i == 7)) begin
        n_err++; $display("FAIL bp_out_row%0d data=%h last=%b want data=%h last=%b", i, obs_o[i], obs_last[i], model_acc[i], i == 7);
      end
    end
  endtask

  task automatic test_boundaries;
    row_t a[ROWS]; row_t ec[ROWS];
    for (int i = 0; i < ROWS; i++) a[i] = rand_row();
    ref_pass(0, 1'b1, a, ec);
    run_pass(0, 5'd1, 1'b1, 1'b1, a, 1'b0, 0, 0);
    n_chk++; if (timed_out !== 1'b0 || obs_o.size() !== 1 || obs_a.size() !== 1) begin
      n_err++; $display("FAIL bnd_one_counts timeout=%b macs=%0d outs=%0d want 0/1/1", timed_out, obs_a.size(), obs_o.size());
    end
    n_chk++; if (obs_o.size() > 0 && (obs_o[0] !== model_acc[0] || obs_last[0] !== 1'b1)) begin
      n_err++; $display("FAIL bnd_one_row data=%h last=%b want data=%h last=1", obs_o[0], obs_last[0], model_acc[0]);
    end
    for (int i = 0; i < ROWS; i++) a[i] = rand_row();
    a[0] = {4{16'hFFFF}};
    ref_pass(ROWS - 1, 1'b1, a, ec);
    run_pass(ROWS - 1, 5'd30, 1'b1, 1'b0, a, 1'b0, 0, 0);
    n_chk++; if (timed_out !== 1'b0 || obs_a.size() !== ROWS) begin n_err++; $display("FAIL bnd_full1 timeout=%b macs=%0d want 0/%0d", timed_out, obs_a.size(), ROWS); end
    for (int i = 0; i < ROWS; i++) a[i] = rand_row();
    a[0] = {4{16'h0001}};
    ref_pass(ROWS - 1, 1'b0, a, ec);
    run_pass(ROWS - 1, 5'd31, 1'b0, 1'b1, a, 1'b0, 0, 0);
    n_chk++; if (timed_out !== 1'b0 || obs_o.size() !== ROWS) begin n_err++; $display("FAIL bnd_full2 timeout=%b outs=%0d want 0/%0d", timed_out, obs_o.size(), ROWS); end
    for (int i = 0; i < obs_c.size() && i < ROWS; i++) begin
      n_chk++; if (obs_c[i] !== ec[i]) begin n_err++; $display("FAIL bnd_full_c_row%0d got=%h want=%h", i, obs_c[i], ec[i]); end
    end
    for (int i = 0; i < obs_o.size() && i < ROWS; i++) begin
      n_chk++; if (obs_o[i] !== model_acc[i] || obs_last[i] !== (i == ROWS - 1)) begin
        n_err++; $display("FAIL bnd_full_out_row%0d data=%h last=%b want data=%h last=%b", i, obs_o[i], obs_last[i], model_acc[i], i == ROWS - 1);
      end
    end
    n_chk++; if (obs_o.size() > 0 && obs_o[0] !== '0) begin n_err++; $display("FAIL bnd_wrap got=%h want=0", obs_o[0]); end
  endtask

  task automatic test_reset_midpass;
    row_t a[ROWS]; row_t ec[ROWS];
    @(negedge clock);
    n_chk++; if (bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rst_mid_idle cmd_rdy=%b want=1", bus.cmd_rdy); end
    bus.cmd_v = 1'b1; bus.cmd_rows = RW'(7); bus.cmd_bidx = 5'd4; bus.cmd_first = 1'b1; bus.cmd_last = 1'b1;
    @(negedge clock);
    bus.cmd_v = 1'b0; bus.a_v = 1'b1; bus.a_data = rand_row();
    @(negedge clock);
    bus.a_data = rand_row();
    @(negedge clock);
    n_chk++; if (bus.mac_en !== 1'b1 || bus.a_rdy !== 1'b1) begin n_err++; $display("FAIL rst_mid_feeding mac_en=%b a_rdy=%b want 1/1", bus.mac_en, bus.a_rdy); end
    bus.a_v = 1'b0;
    reset = 1'b1;
    #1;
    n_chk++; if ({bus.mac_en, bus.o_v, bus.a_rdy, bus.cmd_rdy} !== 4'b0) begin
      n_err++; $display("FAIL rst_mid_async mac_en=%b o_v=%b a_rdy=%b cmd_rdy=%b want 0000", bus.mac_en, bus.o_v, bus.a_rdy, bus.cmd_rdy);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_chk++; if (bus.cmd_rdy !== 1'b1 || bus.mac_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_release cmd_rdy=%b mac_en=%b want 1/0", bus.cmd_rdy, bus.mac_en); end
    for (int i = 0; i < ROWS; i++) a[i] = rand_row();
    ref_pass(3, 1'b1, a, ec);
    run_pass(3, 5'd12, 1'b1, 1'b1, a, 1'b0, 0, 0);
    n_chk++; if (timed_out !== 1'b0 || obs_o.size() !== 4) begin n_err++; $display("FAIL rst_mid_fresh timeout=%b outs=%0d want 0/4", timed_out, obs_o.size()); end
    for (int i = 0; i < obs_o.size() && i < 4; i++) begin
      n_chk++; if (obs_o[i] !== model_acc[i] || obs_last[i] !== (i == 3)) begin
        n_err++; $display("FAIL rst_mid_out_row%0d data=%h last=%b want data=%h last=%b", i, obs_o[i], obs_last[i], model_acc[i], i == 3);
      end
    end
  endtask

  initial begin
    bus.cmd_v = 1'b0; bus.cmd_rows = '0; bus.cmd_bidx = '0; bus.cmd_first = 1'b0; bus.cmd_last = 1'b0;
    bus.a_v = 1'b0; bus.a_data = '0; bus.o_rdy = 1'b1;
    for (int i = 0; i < ROWS; i++) model_acc[i] = '0;
    test_reset();
    test_single_pass();
    test_two_pass();
    test_bubbles();
    test_backpressure();
    test_boundaries();
    test_reset_midpass();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
